vlsu_txn_fragmenter: RTL and testbench
======================================

VLSU_TXN_FRAGMENTER -- requirements
Module: vlsu_txn_fragmenter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, meaning nibble-address width.
REQ-002 SHALL have parameter SLEN, default 256, meaning transaction width in bits; SLEN/4 is nibbles per transaction (TN).
REQ-003 SHALL have parameter NR_LANES, default 4, meaning the lane count used for the row-2D segment size.
REQ-004 SHALL have parameter VLEN, default 4096, meaning VLEN_BITS = $clog2(VLEN)+1 sizes all nibble counters.
REQ-005 SHALL have ports clk_i input 1, the single clock, and rst_ni input 1, a reset that is synchronous and active-low.
REQ-006 SHALL have ports req_valid_i input 1 and req_ready_o output 1, the request handshake.
REQ-007 SHALL have the following request inputs:
- req_mode_i, 4 bits, one-hot {cln2D,row2D,strd,incr}.
- req_addr_i, ADDR_BITS.
- req_stride_i, ADDR_BITS, nibble distance between segment bases.
- req_sew_i, 2 bits, log2 nibbles per element.
- req_nr_elem_i, VLEN_BITS.
- req_nr_seg_i, 8 bits, segments per group minus 1.
- req_nr_grp_i, 8 bits, groups minus 1.
REQ-008 SHALL have ports txn_valid_o output 1 and txn_ready_i input 1, the transaction handshake.
REQ-009 SHALL have the following transaction outputs:
- txn_addr_o, ADDR_BITS.
- txn_nbs_o, $clog2(TN)+1 bits, valid nibbles in the transaction.
- txn_last_o, 1 bit, last transaction of a segment.
- txn_final_o, 1 bit, last transaction of the request.
REQ-010 SHALL have ports busy_o output 1, high whenever state is not IDLE.

Function
REQ-011 SHALL use FSM states IDLE, INIT and ISSUE; IDLE goes to INIT on req handshake, INIT goes to ISSUE after 1 cycle, and ISSUE goes to INIT on a non-final txn_last handshake or to IDLE on a txn_final handshake.
REQ-012 SHALL assert req_ready_o only in IDLE, and SHALL register all req fields into global state (rmnSeg=nr_seg, rmnGrp=nr_grp) on handshake.
REQ-013 SHALL, in INIT, compute segment nbs as follows:
- incr: nr_elem<<sew.
- strd: 1<<sew.
- row2D: NR_LANES<<sew.
- cln2D: TN, except on the last group (rmnGrp==0), where it is (nr_elem<<sew) mod TN, with a result of 0 replaced by TN.
REQ-014 SHALL, in INIT, compute:
- off = segBase[log2 TN-1:0].
- tot = off + nbs.
- txnNum = (tot-1)>>log2 TN.
- txnCnt = 0.
- ltN = tot mod TN, with a result of 0 replaced by TN.
REQ-015 SHALL drive txn_addr_o = segBase when txnCnt==0, and (segBase & ~(TN-1)) + txnCnt*TN otherwise.
REQ-016 SHALL drive txn_nbs_o as follows:
- nbs when txnNum==0.
- TN-off when txnCnt==0.
- ltN when txnCnt==txnNum.
- TN otherwise.
REQ-017 SHALL assert txn_last_o when txnCnt==txnNum, and txn_final_o when txn_last_o && rmnSeg==0 && rmnGrp==0.
REQ-018 SHALL increment txnCnt on each txn handshake.
REQ-019 SHALL, on a segment-last handshake:
- set segBase += stride (wrapping modulo 2^ADDR_BITS);
- if rmnSeg!=0, decrement rmnSeg;
- otherwise decrement rmnGrp and reload rmnSeg = nr_seg.
REQ-020 SHALL hold every txn output stable while txn_valid_o && !txn_ready_i.
REQ-021 SHALL assert txn_valid_o only in ISSUE; first-transaction latency is 2 cycles after the req handshake.
REQ-022 SHALL ignore req_valid_i while busy; no request is queued.
REQ-023 SHALL treat a mode that is not one-hot as incr.

Reset
REQ-024 SHALL, on a rising clk_i edge with rst_ni low, set the following, including mid-ISSUE, discarding the in-flight request:
- state=IDLE.
- txn_valid_o=0.
- req_ready_o=1 once out of reset.
- busy_o=0.
- all counters and address registers = 0.

Configuration
REQ-025 SHALL, with VLSU_FRAG_STATS_EN defined, add output perf_txn_cnt_o (32 bits), incremented on every txn handshake, saturating, and cleared by reset; without VLSU_FRAG_STATS_EN the port and logic SHALL be absent.

Structure
REQ-026 SHALL place the following in a shared vlsu_frag_pkg:
- types meta_glb_t and meta_seglv_t;
- mode bit indices;
- mode helpers isIncr, isStrd, isRow2D, isCln2D, isLastSeg, isLastGrp, isLastTxn, isFinalTxn;
- the seg-init function.
REQ-027 SHALL put all sequential logic in the single module, with no sub-module.

Verification (TN=64)
REQ-028 SHALL verify incr, addr 0x10, sew=1, nr_elem=40 -> txns (0x10,48,last=0) then (0x40,32,last=1,final=1).
REQ-029 SHALL verify strd, addr 0, stride 0x100, sew=2, nr_seg=2, nr_grp=0 -> txns (0x0,4), (0x100,4), (0x200,4,final=1), each with last=1.
REQ-030 SHALL verify cln2D, sew=1, nr_elem=20, nr_grp=1, nr_seg=0, stride 0x40, addr 0 -> (0x0,64,last) then (0x40,40,final).
REQ-031 SHALL verify that txn_ready_i held low for 5 cycles mid-request leaves addr, nbs and flags unchanged, and no transaction is lost or duplicated.
REQ-032 SHALL verify that rst_ni low for 1 cycle during ISSUE gives txn_valid_o=0 and busy_o=0 next cycle, and a new request then completes normally.
REQ-033 SHALL verify that, with VLSU_FRAG_STATS_EN, scenario REQ-029 ends with perf_txn_cnt_o=3.

Source files
------------

// File: rtl/vlsu_frag_pkg.sv
// Shared types and helpers for the VLSU transaction fragmenter:
// per-request/per-segment metadata, mode decoding and the segment-init math.
package vlsu_frag_pkg;

  localparam int unsigned MODE_INCR  = 0;
  localparam int unsigned MODE_STRD  = 1;
  localparam int unsigned MODE_ROW2D = 2;
  localparam int unsigned MODE_CLN2D = 3;

  // Wide enough for (nr_elem << 3) plus a sub-transaction offset at any sane VLEN.
  localparam int unsigned CNT_W = 24;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] mode;
    logic [1:0] sew;
    logic [7:0] nr_seg;
    logic [7:0] nr_grp;
    logic [7:0] rmn_seg;
    logic [7:0] rmn_grp;
  } meta_glb_t;

  typedef struct packed {
    cnt_t nbs;
    cnt_t off;
    cnt_t txn_num;
    cnt_t txn_cnt;
    cnt_t lt_n;
  } meta_seglv_t;

  function automatic logic isStrd(input logic [3:0] mode);
    return mode == (4'd1 << MODE_STRD);
  endfunction

  function automatic logic isRow2D(input logic [3:0] mode);
    return mode == (4'd1 << MODE_ROW2D);
  endfunction

  function automatic logic isCln2D(input logic [3:0] mode);
    return mode == (4'd1 << MODE_CLN2D);
  endfunction

  // Anything that is not a clean one-hot strd/row2D/cln2D falls back to incr.
  function automatic logic isIncr(input logic [3:0] mode);
    return !(isStrd(mode) || isRow2D(mode) || isCln2D(mode));
  endfunction

  function automatic logic isLastSeg(input meta_glb_t glb);
    return glb.rmn_seg == 8'd0;
  endfunction

  function automatic logic isLastGrp(input meta_glb_t glb);
    return glb.rmn_grp == 8'd0;
  endfunction

  function automatic logic isLastTxn(input meta_seglv_t seg);
    return seg.txn_cnt == seg.txn_num;
  endfunction

  function automatic logic isFinalTxn(input meta_glb_t glb, input meta_seglv_t seg);
    return isLastTxn(seg) && isLastSeg(glb) && isLastGrp(glb);
  endfunction

  function automatic meta_seglv_t seg_init(
    input logic [3:0] mode,
    input logic [1:0] sew,
    input cnt_t       nr_elem,
    input cnt_t       nr_lanes,
    input int         log_tn,
    input logic       last_grp,
    input cnt_t       off
  );
    meta_seglv_t seg;
    cnt_t tn;
    cnt_t mask;
    cnt_t elem_nbs;
    cnt_t tot;
    tn       = cnt_t'(1) << log_tn;
    mask     = tn - cnt_t'(1);
    elem_nbs = nr_elem << sew;
    if (isIncr(mode)) begin
      seg.nbs = elem_nbs;
    end else if (isStrd(mode)) begin
      seg.nbs = cnt_t'(1) << sew;
    end else if (isRow2D(mode)) begin
      seg.nbs = nr_lanes << sew;
    end else if (last_grp && ((elem_nbs & mask) != cnt_t'(0))) begin
      seg.nbs = elem_nbs & mask;
    end else begin
      seg.nbs = tn;
    end
    seg.off     = off;
    tot         = off + seg.nbs;
    // An empty segment still issues one (zero-length) transaction.
    seg.txn_num = (tot == cnt_t'(0)) ? cnt_t'(0) : ((tot - cnt_t'(1)) >> log_tn);
    seg.txn_cnt = cnt_t'(0);
    seg.lt_n    = ((tot & mask) == cnt_t'(0)) ? tn : (tot & mask);
    return seg;
  endfunction

endpackage

// File: rtl/vlsu_txn_fragmenter.sv
// Splits incr/strided/2D vector memory requests into SLEN-wide aligned transactions.
// Optional VLSU_FRAG_STATS_EN adds a saturating handshake counter perf_txn_cnt_o.
module vlsu_txn_fragmenter
  import vlsu_frag_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int SLEN      = 256,
  parameter int NR_LANES  = 4,
  parameter int VLEN      = 4096,
  localparam int TN        = SLEN / 4,
  localparam int LOG_TN    = $clog2(TN),
  localparam int NBS_W     = $clog2(TN) + 1,
  localparam int VLEN_BITS = $clog2(VLEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [3:0]           req_mode_i,
  input  logic [ADDR_BITS-1:0] req_addr_i,
  input  logic [ADDR_BITS-1:0] req_stride_i,
  input  logic [1:0]           req_sew_i,
  input  logic [VLEN_BITS-1:0] req_nr_elem_i,
  input  logic [7:0]           req_nr_seg_i,
  input  logic [7:0]           req_nr_grp_i,
  output logic                 txn_valid_o,
  input  logic                 txn_ready_i,
  output logic [ADDR_BITS-1:0] txn_addr_o,
  output logic [NBS_W-1:0]     txn_nbs_o,
  output logic                 txn_last_o,
  output logic                 txn_final_o,
  output logic                 busy_o
`ifdef VLSU_FRAG_STATS_EN
  ,
  output logic [31:0]          perf_txn_cnt_o
`endif
);

  localparam logic [ADDR_BITS-1:0] TN_MASK = ADDR_BITS'(TN - 1);

  state_e                 state_q, state_d;
  meta_glb_t              glb_q, glb_d;
  meta_seglv_t            seg_q, seg_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [ADDR_BITS-1:0]   stride_q, stride_d;
  logic [VLEN_BITS-1:0]   nr_elem_q, nr_elem_d;
  logic                   valid_q, valid_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [NBS_W-1:0]       nbs_q, nbs_d;
  logic                   last_q, last_d;
  logic                   final_q, final_d;
  logic                   txn_hs;

  assign txn_hs      = valid_q && txn_ready_i;
  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign txn_valid_o = valid_q;
  assign txn_addr_o  = addr_q;
  assign txn_nbs_o   = nbs_q;
  assign txn_last_o  = last_q;
  assign txn_final_o = final_q;

  always_comb begin
    state_d   = state_q;
    glb_d     = glb_q;
    seg_d     = seg_q;
    base_d    = base_q;
    stride_d  = stride_q;
    nr_elem_d = nr_elem_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          glb_d.mode    = req_mode_i;
          glb_d.sew     = req_sew_i;
          glb_d.nr_seg  = req_nr_seg_i;
          glb_d.nr_grp  = req_nr_grp_i;
          glb_d.rmn_seg = req_nr_seg_i;
          glb_d.rmn_grp = req_nr_grp_i;
          base_d        = req_addr_i;
          stride_d      = req_stride_i;
          nr_elem_d     = req_nr_elem_i;
          state_d       = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        seg_d   = seg_init(glb_q.mode, glb_q.sew, cnt_t'(nr_elem_q), cnt_t'(NR_LANES),
                           LOG_TN, isLastGrp(glb_q), cnt_t'(base_q[LOG_TN-1:0]));
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (txn_hs) begin
          if (isFinalTxn(glb_q, seg_q)) begin
            base_d  = base_q + stride_q;
            state_d = ST_IDLE;
          end else if (isLastTxn(seg_q)) begin
            base_d = base_q + stride_q;
            if (!isLastSeg(glb_q)) begin
              glb_d.rmn_seg = glb_q.rmn_seg - 8'd1;
            end else begin
              glb_d.rmn_grp = glb_q.rmn_grp - 8'd1;
              glb_d.rmn_seg = glb_q.nr_seg;
            end
            state_d = ST_INIT;
          end else begin
            seg_d.txn_cnt = seg_q.txn_cnt + cnt_t'(1);
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output fields are precomputed from next-state so the txn port is fully registered.
  always_comb begin
    valid_d = (state_d == ST_ISSUE);
    if (seg_d.txn_cnt == cnt_t'(0)) begin
      addr_d = base_d;
    end else begin
      addr_d = (base_d & ~TN_MASK) + ADDR_BITS'(seg_d.txn_cnt << LOG_TN);
    end
    if (seg_d.txn_num == cnt_t'(0)) begin
      nbs_d = NBS_W'(seg_d.nbs);
    end else if (seg_d.txn_cnt == cnt_t'(0)) begin
      nbs_d = NBS_W'(cnt_t'(TN) - seg_d.off);
    end else if (isLastTxn(seg_d)) begin
      nbs_d = NBS_W'(seg_d.lt_n);
    end else begin
      nbs_d = NBS_W'(TN);
    end
    last_d  = isLastTxn(seg_d);
    final_d = isFinalTxn(glb_d, seg_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      glb_q     <= '0;
      seg_q     <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      nr_elem_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      nbs_q     <= '0;
      last_q    <= 1'b0;
      final_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      glb_q     <= glb_d;
      seg_q     <= seg_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      nr_elem_q <= nr_elem_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      nbs_q     <= nbs_d;
      last_q    <= last_d;
      final_q   <= final_d;
    end
  end

`ifdef VLSU_FRAG_STATS_EN
  logic [31:0] perf_cnt_q;
  assign perf_txn_cnt_o = perf_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_cnt_q <= 32'd0;
    end else if (txn_hs && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end else begin
      perf_cnt_q <= perf_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_vlsu_txn_fragmenter.sv
// Directed self-checking bench for vlsu_txn_fragmenter at default parameters (TN=64).
module tb_vlsu_txn_fragmenter;
  import vlsu_frag_pkg::*;

  localparam int ADDR_BITS = 32;
  localparam int VLEN_BITS = 13;
  localparam int NBS_W     = 7;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic [3:0]           req_mode_i = 4'd0;
  logic [ADDR_BITS-1:0] req_addr_i = '0;
  logic [ADDR_BITS-1:0] req_stride_i = '0;
  logic [1:0]           req_sew_i = 2'd0;
  logic [VLEN_BITS-1:0] req_nr_elem_i = '0;
  logic [7:0]           req_nr_seg_i = 8'd0;
  logic [7:0]           req_nr_grp_i = 8'd0;
  logic                 txn_valid_o;
  logic                 txn_ready_i = 1'b1;
  logic [ADDR_BITS-1:0] txn_addr_o;
  logic [NBS_W-1:0]     txn_nbs_o;
  logic                 txn_last_o;
  logic                 txn_final_o;
  logic                 busy_o;
`ifdef VLSU_FRAG_STATS_EN
  logic [31:0]          perf_txn_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vlsu_txn_fragmenter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_mode_i    (req_mode_i),
    .req_addr_i    (req_addr_i),
    .req_stride_i  (req_stride_i),
    .req_sew_i     (req_sew_i),
    .req_nr_elem_i (req_nr_elem_i),
    .req_nr_seg_i  (req_nr_seg_i),
    .req_nr_grp_i  (req_nr_grp_i),
    .txn_valid_o   (txn_valid_o),
    .txn_ready_i   (txn_ready_i),
    .txn_addr_o    (txn_addr_o),
    .txn_nbs_o     (txn_nbs_o),
    .txn_last_o    (txn_last_o),
    .txn_final_o   (txn_final_o),
    .busy_o        (busy_o)
`ifdef VLSU_FRAG_STATS_EN
    ,
    .perf_txn_cnt_o(perf_txn_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [3:0] mode, input logic [31:0] addr, input logic [31:0] stride,
                          input logic [1:0] sew, input int nr_elem, input int nr_seg, input int nr_grp);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req_ready_o) break;
    end
    if (i == 20) check_val("req_ready_timeout", 64'd0, 64'd1);
    req_mode_i    = mode;
    req_addr_i    = addr;
    req_stride_i  = stride;
    req_sew_i     = sew;
    req_nr_elem_i = VLEN_BITS'(nr_elem);
    req_nr_seg_i  = 8'(nr_seg);
    req_nr_grp_i  = 8'(nr_grp);
    req_valid_i   = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input logic [31:0] addr, input int nbs,
                            input logic last, input logic fin);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (txn_valid_o) break;
    end
    if (i == 20) begin
      check_val({tag, "_valid_timeout"}, 64'd0, 64'd1);
    end else begin
      check_val({tag, "_addr"}, 64'(txn_addr_o), 64'(addr));
      check_val({tag, "_nbs"}, 64'(txn_nbs_o), 64'(nbs));
      check_val({tag, "_last"}, 64'(txn_last_o), 64'(last));
      check_val({tag, "_final"}, 64'(txn_final_o), 64'(fin));
    end
  endtask

  task automatic expect_idle(input string tag);
    repeat (2) @(negedge clk_i);
    check_val({tag, "_idle_valid"}, 64'(txn_valid_o), 64'd0);
    check_val({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("rst_valid", 64'(txn_valid_o), 64'd0);
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_ready", 64'(req_ready_o), 64'd1);

    // strided, three segments of one 4-nibble txn each
    send_req(4'b0010, 32'h0, 32'h100, 2'd2, 1, 2, 0);
    check_val("busy_after_req", 64'(busy_o), 64'd1);
    check_val("ready_after_req", 64'(req_ready_o), 64'd0);
    expect_txn("strd0", 32'h000, 4, 1'b1, 1'b0);
    expect_txn("strd1", 32'h100, 4, 1'b1, 1'b0);
    expect_txn("strd2", 32'h200, 4, 1'b1, 1'b1);
    expect_idle("strd");
`ifdef VLSU_FRAG_STATS_EN
    check_val("perf_cnt", 64'(perf_txn_cnt_o), 64'd3);
`endif

    // incr crossing one 64-nibble boundary
    send_req(4'b0001, 32'h10, 32'h0, 2'd1, 40, 0, 0);
    expect_txn("incr0", 32'h10, 48, 1'b0, 1'b0);
    expect_txn("incr1", 32'h40, 32, 1'b1, 1'b1);
    expect_idle("incr");

    // cln2D: full TN for first group, remainder on last group
    send_req(4'b1000, 32'h0, 32'h40, 2'd1, 20, 0, 1);
    expect_txn("cln0", 32'h00, 64, 1'b1, 1'b0);
    expect_txn("cln1", 32'h40, 40, 1'b1, 1'b1);
    expect_idle("cln");

    // row2D: 4 lanes << 0 = 4 nibbles starting 2 below a boundary
    send_req(4'b0100, 32'h3E, 32'h0, 2'd0, 1, 0, 0);
    expect_txn("row0", 32'h3E, 2, 1'b0, 1'b0);
    expect_txn("row1", 32'h40, 2, 1'b1, 1'b1);

    // non-one-hot mode behaves as incr
    send_req(4'b0011, 32'h10, 32'h0, 2'd1, 40, 0, 0);
    expect_txn("nohot0", 32'h10, 48, 1'b0, 1'b0);
    expect_txn("nohot1", 32'h40, 32, 1'b1, 1'b1);
    expect_idle("nohot");

    // back-pressure: first txn must hold for 5 stalled cycles
    txn_ready_i = 1'b0;
    send_req(4'b0001, 32'h10, 32'h0, 2'd1, 40, 0, 0);
    expect_txn("stall0", 32'h10, 48, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check_val("stall_valid", 64'(txn_valid_o), 64'd1);
      check_val("stall_addr", 64'(txn_addr_o), 64'h10);
      check_val("stall_nbs", 64'(txn_nbs_o), 64'd48);
      check_val("stall_flags", 64'({txn_last_o, txn_final_o}), 64'd0);
    end
    txn_ready_i = 1'b1;
    expect_txn("stall1", 32'h40, 32, 1'b1, 1'b1);
    expect_idle("stall");

    // reset mid-ISSUE discards the request
    txn_ready_i = 1'b0;
    send_req(4'b0010, 32'h0, 32'h100, 2'd2, 1, 2, 0);
    expect_txn("prerst", 32'h000, 4, 1'b1, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check_val("midrst_valid", 64'(txn_valid_o), 64'd0);
    check_val("midrst_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    txn_ready_i = 1'b1;
    send_req(4'b0001, 32'h10, 32'h0, 2'd1, 40, 0, 0);
    expect_txn("postrst0", 32'h10, 48, 1'b0, 1'b0);
    expect_txn("postrst1", 32'h40, 32, 1'b1, 1'b1);
    expect_idle("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
